// File: rtl/btn_pkg.sv
// Shared channel indices, debounce FSM state type and counter sizing helper
// for the push-button front end.
package btn_pkg;

  localparam int BTN_SALUD     = 0;
  localparam int BTN_ENERGIA   = 1;
  localparam int BTN_HAMBRE    = 2;
  localparam int BTN_DIVERSION = 3;
  localparam int BTN_RESET     = 4;
  localparam int BTN_TEST      = 5;
  localparam int N_BTN         = 6;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  // Bits needed to hold every value 0..max_val without wrapping.
  function automatic int cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, debounce FSM, optional long-press timer
// and the output pulse stretcher.
//
// state      | meaning
// IDLE       | released and stable, waiting for a press level
// PRESS_WAIT | press level seen, checking it stays stable
// HELD       | debounced press, level output high
// REL_WAIT   | release level seen, checking it stays stable
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 250_000_000,
  parameter int unsigned STRETCH_CYC  = 5_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          LONG_EN      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int SW = cnt_w(STRETCH_CYC);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q;
  logic [DW-1:0] dbc_q;
  logic          level_q;
  logic [SW-1:0] stretch_q, stretch_d;
  logic          pulse_q;

  logic dbc_done, press_evt, long_evt, trig;

  // Polarity is folded in ahead of the flops so their reset value reads as
  // "released"; a pin held through reset then sees the full sync latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i ^ ACTIVE_LOW;
      sync2_q <= sync1_q;
    end
  end

  assign dbc_done  = (dbc_q == DW'(DEBOUNCE_CYC - 1));
  assign press_evt = (state_q == PRESS_WAIT) && sync2_q && dbc_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dbc_q   <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= PRESS_WAIT;
            dbc_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_q <= IDLE;
          end else if (dbc_done) begin
            state_q <= HELD;
            level_q <= 1'b1;
          end else begin
            dbc_q <= dbc_q + 1'b1;
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= REL_WAIT;
            dbc_q   <= '0;
          end
        end
        REL_WAIT: begin
          if (sync2_q) begin
            state_q <= HELD;
          end else if (dbc_done) begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end else begin
            dbc_q <= dbc_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    if (LONG_EN) begin : g_long
      localparam int LW = cnt_w(LONG_CYC);
      logic [LW-1:0] hold_q;

      // Saturates one past the firing value so the long event is single-shot.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_q <= '0;
        end else if (!level_q) begin
          hold_q <= '0;
        end else if (hold_q != LW'(LONG_CYC)) begin
          hold_q <= hold_q + 1'b1;
        end
      end

      assign long_evt = level_q && (hold_q == LW'(LONG_CYC - 1));
    end else begin : g_no_long
      assign long_evt = 1'b0;
    end
  endgenerate

  assign trig = LONG_EN ? long_evt : press_evt;

  always_comb begin
    stretch_d = stretch_q;
    if (trig) begin
      stretch_d = SW'(STRETCH_CYC);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      stretch_q <= stretch_d;
      pulse_q   <= (stretch_d != '0);
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Six-channel push-button front end: debounced levels plus stretched press
// pulses (care buttons) and stretched long-press pulses (reset, test).
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 250_000_000,
  parameter int unsigned STRETCH_CYC  = 5_000_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             btn_salud,
  output logic             btn_energia,
  output logic             btn_hambre,
  output logic             btn_diversion,
  output logic             btn_reset,
  output logic             btn_test
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] pulse_w;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .STRETCH_CYC  (STRETCH_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .LONG_EN      (g >= BTN_RESET)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_raw[g]),
      .level_o (level_w[g]),
      .pulse_o (pulse_w[g])
    );
  end

  assign btn_level     = level_w;
  assign btn_salud     = pulse_w[BTN_SALUD];
  assign btn_energia   = pulse_w[BTN_ENERGIA];
  assign btn_hambre    = pulse_w[BTN_HAMBRE];
  assign btn_diversion = pulse_w[BTN_DIVERSION];
  assign btn_reset     = pulse_w[BTN_RESET];
  assign btn_test      = pulse_w[BTN_TEST];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected output transitions, a monitor
// pops and compares on every observed output change.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [5:0] btn_raw;
  logic [5:0] btn_level;
  logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;

  button_conditioner #(
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .STRETCH_CYC  (6),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .btn_salud     (btn_salud),
    .btn_energia   (btn_energia),
    .btn_hambre    (btn_hambre),
    .btn_diversion (btn_diversion),
    .btn_reset     (btn_reset),
    .btn_test      (btn_test)
  );

  // Observed bits: 0..5 level, 6 salud, 7 energia, 8 hambre, 9 diversion,
  // 10 reset, 11 test.
  logic [11:0] obs;
  assign obs = {btn_test, btn_reset, btn_diversion, btn_hambre, btn_energia, btn_salud, btn_level};

  typedef struct {
    int cyc;
    int sig;
    bit val;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [11:0] prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int i = 0; i < 12; i++) begin
        if (obs[i] !== prev[i]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_edge: sig=%0d val=%b at cycle %0d, none expected", i, obs[i], cyc);
          end else begin
            ev_t e;
            e = q.pop_front();
            if (e.sig != i || e.val !== obs[i] || e.cyc != cyc) begin
              errors++;
              $display("FAIL edge: got sig=%0d val=%b cyc=%0d, expected sig=%0d val=%b cyc=%0d",
                       i, obs[i], cyc, e.sig, e.val, e.cyc);
            end
          end
        end
      end
      prev = obs;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input int s, input bit v);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    tick(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected edges never seen, required 0", name, q.size());
      q.delete();
    end
  endtask

  int e0, d0;

  initial begin
    rst     = 1'b1;
    btn_raw = 6'h3F;
    tick(3);
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: outputs=%h required 000", obs);
    end
    rst  = 1'b0;
    prev = obs;
    mon_en = 1'b1;
    tick(5);

    // Clean press, channel 0
    e0 = cyc;
    btn_raw[0] = 1'b0;
    expect_ev(e0 + 7, 0, 1'b1);
    expect_ev(e0 + 7, 6, 1'b1);
    expect_ev(e0 + 13, 6, 1'b0);
    tick(30);
    btn_raw[0] = 1'b1;
    expect_ev(e0 + 37, 0, 1'b0);
    drain("clean_press");

    // Glitch rejection, channel 2
    e0 = cyc;
    btn_raw[2] = 1'b0;
    tick(3);
    btn_raw[2] = 1'b1;
    tick(5);
    checks++;
    if (btn_level[2] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level: btn_level[2]=%b required 0", btn_level[2]);
    end
    tick(15);

    // Long press, channel 4
    e0 = cyc;
    btn_raw[4] = 1'b0;
    expect_ev(e0 + 7, 4, 1'b1);
    expect_ev(e0 + 27, 10, 1'b1);
    expect_ev(e0 + 33, 10, 1'b0);
    tick(40);
    btn_raw[4] = 1'b1;
    expect_ev(e0 + 47, 4, 1'b0);
    drain("long_press");

    // Short press on channel 4: level only, no long pulse
    e0 = cyc;
    btn_raw[4] = 1'b0;
    expect_ev(e0 + 7, 4, 1'b1);
    tick(10);
    btn_raw[4] = 1'b1;
    expect_ev(e0 + 17, 4, 1'b0);
    drain("short_long");
    tick(20);

    // Release bounce, channel 3
    e0 = cyc;
    btn_raw[3] = 1'b0;
    expect_ev(e0 + 7, 3, 1'b1);
    expect_ev(e0 + 7, 9, 1'b1);
    expect_ev(e0 + 13, 9, 1'b0);
    tick(20);
    btn_raw[3] = 1'b1; tick(2);
    btn_raw[3] = 1'b0; tick(2);
    btn_raw[3] = 1'b1; tick(2);
    btn_raw[3] = 1'b0; tick(2);
    btn_raw[3] = 1'b1;
    expect_ev(e0 + 35, 3, 1'b0);
    drain("bounce");

    // Reset mid-press, channel 5 with hold count at 15
    e0 = cyc;
    btn_raw[5] = 1'b0;
    expect_ev(e0 + 7, 5, 1'b1);
    tick(22);
    expect_ev(e0 + 22, 5, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_midpress: outputs=%h required 000", obs);
    end
    tick(3);
    rst = 1'b0;
    d0 = cyc;
    expect_ev(d0 + 7, 5, 1'b1);
    expect_ev(d0 + 27, 11, 1'b1);
    expect_ev(d0 + 33, 11, 1'b0);
    tick(40);
    btn_raw[5] = 1'b1;
    expect_ev(d0 + 47, 5, 1'b0);
    drain("reset_midpress");

    // Simultaneous press, channels 0 and 1
    e0 = cyc;
    btn_raw[1:0] = 2'b00;
    expect_ev(e0 + 7, 0, 1'b1);
    expect_ev(e0 + 7, 1, 1'b1);
    expect_ev(e0 + 7, 6, 1'b1);
    expect_ev(e0 + 7, 7, 1'b1);
    expect_ev(e0 + 13, 6, 1'b0);
    expect_ev(e0 + 13, 7, 1'b0);
    tick(20);
    btn_raw[1:0] = 2'b11;
    expect_ev(e0 + 27, 0, 1'b0);
    expect_ev(e0 + 27, 1, 1'b0);
    drain("simultaneous");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
